// File: rtl/rx_capture_writer.sv
// rx_capture_writer
//
// Receive-chain stage that sits behind the sample discriminator. On arm it
// restarts the discriminator (adc_reset_state_o), then streams every valid
// per-channel sample and timestamp into per-channel memories until stopped.
// When the capture ends it emits one AXI-Stream summary beat per channel.
//
// Summary beat layout, LSB first:
//   sample_count[SA_W:0], tstamp_count[TA_W:0], sample_ovf, tstamp_ovf,
//   channel index[CH_W-1:0]
//
// Optional feature macro: RX_CAPTURE_AUTO_STOP_EN
//   When defined, a capture also ends in the first cycle in which every
//   channel's sample memory is full, exactly as if adc_stop_i had been
//   asserted in that cycle. When undefined, only adc_stop_i ends a capture.
//
// The source-stream interfaces are flattened into plain ports: *_data_i is a
// packed per-channel array and *_valid_i carries one valid bit per channel.
// CHANNELS must be at least 2 so that the channel index field is non-empty.

module rx_capture_writer #(
    parameter int SAMPLE_DEPTH = 16384,
    parameter int TSTAMP_DEPTH = 512,
    parameter int CHANNELS     = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int TSTAMP_WIDTH = 64,
    localparam int SA_W  = $clog2(SAMPLE_DEPTH),
    localparam int TA_W  = $clog2(TSTAMP_DEPTH),
    localparam int CH_W  = $clog2(CHANNELS),
    localparam int SUM_W = CH_W + SA_W + TA_W + 4
) (
    input  logic                                    adc_clk_i,
    input  logic                                    adc_reset_i,

    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]     adc_data_in_data_i,
    input  logic [CHANNELS-1:0]                     adc_data_in_valid_i,
    input  logic [CHANNELS-1:0][TSTAMP_WIDTH-1:0]   adc_timestamps_in_data_i,
    input  logic [CHANNELS-1:0]                     adc_timestamps_in_valid_i,

    input  logic                                    adc_arm_i,
    input  logic                                    adc_stop_i,

    output logic                                    adc_reset_state_o,

    output logic [CHANNELS-1:0]                     adc_sample_we_o,
    output logic [CHANNELS-1:0][SA_W-1:0]           adc_sample_addr_o,
    output logic [CHANNELS-1:0][DATA_WIDTH-1:0]     adc_sample_data_o,

    output logic [CHANNELS-1:0]                     adc_tstamp_we_o,
    output logic [CHANNELS-1:0][TA_W-1:0]           adc_tstamp_addr_o,
    output logic [CHANNELS-1:0][TSTAMP_WIDTH-1:0]   adc_tstamp_data_o,

    output logic [SUM_W-1:0]                        adc_summary_data_o,
    output logic                                    adc_summary_valid_o,
    input  logic                                    adc_summary_ready_i,
    output logic                                    adc_summary_last_o,

    output logic                                    adc_capturing_o
);

    localparam int SA_CW = SA_W + 1;
    localparam int TA_CW = TA_W + 1;

    localparam logic [SA_CW-1:0] SAMPLE_FULL = SA_CW'(SAMPLE_DEPTH);
    localparam logic [TA_CW-1:0] TSTAMP_FULL = TA_CW'(TSTAMP_DEPTH);
    localparam logic [SA_CW-1:0] SAMPLE_ONE  = SA_CW'(1);
    localparam logic [TA_CW-1:0] TSTAMP_ONE  = TA_CW'(1);
    localparam logic [CH_W-1:0]  CH_ONE      = CH_W'(1);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SUMMARY
    } state_t;

    state_t                                 state_q;
    logic                                   reset_state_q;
    logic                                   capturing_q;

    // Per-channel counts double as write pointers: a count below depth is the
    // next free address, and a count equal to depth means the memory is full.
    logic [SA_CW-1:0]                       sample_cnt_q [CHANNELS];
    logic [TA_CW-1:0]                       tstamp_cnt_q [CHANNELS];
    logic [CHANNELS-1:0]                    sample_ovf_q;
    logic [CHANNELS-1:0]                    tstamp_ovf_q;

    logic [CHANNELS-1:0]                    sample_we_q;
    logic [CHANNELS-1:0][SA_W-1:0]          sample_addr_q;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0]    sample_data_q;
    logic [CHANNELS-1:0]                    tstamp_we_q;
    logic [CHANNELS-1:0][TA_W-1:0]          tstamp_addr_q;
    logic [CHANNELS-1:0][TSTAMP_WIDTH-1:0]  tstamp_data_q;

    // The summary is armed one cycle after leaving CAPTURE (sum_pending_q), so
    // the writes accepted in the stop cycle have landed in the counts before
    // the first beat is built from them.
    logic                                   sum_pending_q;
    logic                                   sum_valid_q;
    logic                                   sum_last_q;
    logic [CH_W-1:0]                        sum_ch_q;
    logic [SUM_W-1:0]                       sum_data_q;

    logic [CH_W-1:0]                        sum_ch_d;
    logic [SUM_W-1:0]                       sum_data_d;
    logic                                   sum_last_d;

    logic                                   end_capture;

`ifdef RX_CAPTURE_AUTO_STOP_EN
    logic                                   all_full;

    // Every channel's sample memory is full: treated like an adc_stop_i.
    always_comb begin
        all_full = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sample_cnt_q[c] != SAMPLE_FULL) begin
                all_full = 1'b0;
            end
        end
    end

    assign end_capture = adc_stop_i | all_full;
`else
    assign end_capture = adc_stop_i;
`endif

    // Build the next summary beat: channel 0 right after the capture ends,
    // otherwise the channel following the one just handed over.
    always_comb begin
        sum_ch_d   = sum_pending_q ? '0 : (sum_ch_q + CH_ONE);
        sum_data_d = {sum_ch_d,
                      tstamp_ovf_q[sum_ch_d],
                      sample_ovf_q[sum_ch_d],
                      tstamp_cnt_q[sum_ch_d],
                      sample_cnt_q[sum_ch_d]};
        sum_last_d = (sum_ch_d == LAST_CH);
    end

    // Control FSM: arm/capture/summary sequencing and all registered control outputs.
    always_ff @(posedge adc_clk_i or posedge adc_reset_i) begin
        if (adc_reset_i) begin
            state_q       <= ST_IDLE;
            reset_state_q <= 1'b0;
            capturing_q   <= 1'b0;
            sum_pending_q <= 1'b0;
            sum_valid_q   <= 1'b0;
            sum_last_q    <= 1'b0;
            sum_ch_q      <= '0;
            sum_data_q    <= '0;
        end else begin
            reset_state_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (adc_arm_i) begin
                        state_q       <= ST_CAPTURE;
                        reset_state_q <= 1'b1;
                        capturing_q   <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (end_capture) begin
                        state_q       <= ST_SUMMARY;
                        capturing_q   <= 1'b0;
                        sum_pending_q <= 1'b1;
                    end
                end
                ST_SUMMARY: begin
                    if (sum_pending_q || (sum_valid_q && adc_summary_ready_i)) begin
                        if (!sum_pending_q && sum_last_q) begin
                            sum_valid_q <= 1'b0;
                            sum_last_q  <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            sum_pending_q <= 1'b0;
                            sum_valid_q   <= 1'b1;
                            sum_ch_q      <= sum_ch_d;
                            sum_data_q    <= sum_data_d;
                            sum_last_q    <= sum_last_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sample path: clear on arm, write while capturing until full, then flag overflow.
    always_ff @(posedge adc_clk_i or posedge adc_reset_i) begin
        if (adc_reset_i) begin
            sample_we_q   <= '0;
            sample_addr_q <= '0;
            sample_data_q <= '0;
            sample_ovf_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sample_cnt_q[c] <= '0;
            end
        end else begin
            sample_we_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (adc_arm_i) begin
                        sample_ovf_q <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            sample_cnt_q[c] <= '0;
                        end
                    end
                end
                ST_CAPTURE: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (adc_data_in_valid_i[c]) begin
                            if (sample_cnt_q[c] == SAMPLE_FULL) begin
                                sample_ovf_q[c] <= 1'b1;
                            end else begin
                                sample_we_q[c]   <= 1'b1;
                                sample_addr_q[c] <= sample_cnt_q[c][SA_W-1:0];
                                sample_data_q[c] <= adc_data_in_data_i[c];
                                sample_cnt_q[c]  <= sample_cnt_q[c] + SAMPLE_ONE;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Timestamp path: same rules as the sample path, against its own depth.
    always_ff @(posedge adc_clk_i or posedge adc_reset_i) begin
        if (adc_reset_i) begin
            tstamp_we_q   <= '0;
            tstamp_addr_q <= '0;
            tstamp_data_q <= '0;
            tstamp_ovf_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                tstamp_cnt_q[c] <= '0;
            end
        end else begin
            tstamp_we_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (adc_arm_i) begin
                        tstamp_ovf_q <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            tstamp_cnt_q[c] <= '0;
                        end
                    end
                end
                ST_CAPTURE: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (adc_timestamps_in_valid_i[c]) begin
                            if (tstamp_cnt_q[c] == TSTAMP_FULL) begin
                                tstamp_ovf_q[c] <= 1'b1;
                            end else begin
                                tstamp_we_q[c]   <= 1'b1;
                                tstamp_addr_q[c] <= tstamp_cnt_q[c][TA_W-1:0];
                                tstamp_data_q[c] <= adc_timestamps_in_data_i[c];
                                tstamp_cnt_q[c]  <= tstamp_cnt_q[c] + TSTAMP_ONE;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign adc_reset_state_o   = reset_state_q;
    assign adc_capturing_o     = capturing_q;
    assign adc_sample_we_o     = sample_we_q;
    assign adc_sample_addr_o   = sample_addr_q;
    assign adc_sample_data_o   = sample_data_q;
    assign adc_tstamp_we_o     = tstamp_we_q;
    assign adc_tstamp_addr_o   = tstamp_addr_q;
    assign adc_tstamp_data_o   = tstamp_data_q;
    assign adc_summary_data_o  = sum_data_q;
    assign adc_summary_valid_o = sum_valid_q;
    assign adc_summary_last_o  = sum_last_q;

endmodule
